// File: rtl/wb_slave_router.sv
// Wishbone slave-side router: decodes the management slave port onto three
// downstream slaves and terminates any cycle a slave fails to ack in time.
module wb_slave_router #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  s_cyc_o,
    output logic        s_stb_o,
    input  logic [2:0]  s_ack_i,
    input  logic [95:0] s_dat_i,
    input  logic        err_clr_i,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUSY, TOERR} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [1:0]  adr_sel;
    logic        slv_ack;
    logic [31:0] slv_dat;
    logic [2:0]  slv_onehot;

    // Write data, byte selects and write enable reach the slaves outside this block.
    logic unused_inputs;
    assign unused_inputs = ^{wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i[2:0]};

    always_comb begin
        adr_sel = 2'd0;
        if (wbs_adr_i[31:3] == 29'h601FFFF) begin
            adr_sel = 2'd2;
        end else if (wbs_adr_i[31:3] == 29'h601FFFE) begin
            adr_sel = 2'd1;
        end
    end

    always_comb begin
        slv_ack    = 1'b0;
        slv_dat    = 32'd0;
        slv_onehot = 3'b000;
        case (sel_q)
            2'd0: begin
                slv_ack    = s_ack_i[0];
                slv_dat    = s_dat_i[31:0];
                slv_onehot = 3'b001;
            end
            2'd1: begin
                slv_ack    = s_ack_i[1];
                slv_dat    = s_dat_i[63:32];
                slv_onehot = 3'b010;
            end
            2'd2: begin
                slv_ack    = s_ack_i[2];
                slv_dat    = s_dat_i[95:64];
                slv_onehot = 3'b100;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        err_d     = err_clr_i ? 1'b0 : err_q;
        err_cnt_d = err_clr_i ? 8'd0 : err_cnt_q;
        s_cyc_o   = 3'b000;
        s_stb_o   = 1'b0;
        wbs_ack_o = 1'b0;
        wbs_dat_o = 32'd0;
        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    sel_d   = adr_sel;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o   = wbs_cyc_i ? slv_onehot : 3'b000;
                s_stb_o   = wbs_stb_i;
                wbs_ack_o = slv_ack;
                wbs_dat_o = slv_dat;
                // A slave ack in the last allowed cycle beats the timeout.
                if (slv_ack) begin
                    state_d = IDLE;
                end else if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = TOERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            TOERR: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = ERR_DATA;
                state_d   = IDLE;
                err_d     = 1'b1;
                // Setting wins over a coincident clear.
                if (err_clr_i) begin
                    err_cnt_d = 8'd1;
                end else if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_router.sv
// Randomized bench for wb_slave_router: expected acks are queued at issue
// and popped by an independent monitor on every master-side ack.
module tb_wb_slave_router;

    localparam int T = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [2:0]  s_cyc_o;
    logic        s_stb_o;
    wire  [2:0]  s_ack_i;
    logic [95:0] s_dat_i;
    logic        err_clr_i;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    logic [2:0]  slave_ack;
    logic [2:0]  stray_ack;
    assign s_ack_i = slave_ack | stray_ack;

    wb_slave_router #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .err_clr_i(err_clr_i), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    // ---------------- clock / reset ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    int cyc_cnt = 0;
    initial forever begin
        @(posedge wb_clk_i);
        cyc_cnt++;
    end

    // ---------------- scoreboard state ----------------
    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          exp_err = 0;
    int          exp_cnt = 0;

    int          resp_delay = 1000;
    logic [31:0] resp_data  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // Reference decode: two 8-byte windows at the top of 0x300F_FFxx.
    function automatic int slave_of(input logic [31:0] adr);
        if (adr >= 32'h300F_FFF8 && adr <= 32'h300F_FFFF) return 2;
        if (adr >= 32'h300F_FFF0 && adr <= 32'h300F_FFF7) return 1;
        return 0;
    endfunction

    // ---------------- slave responder ----------------
    // The selected slave acks in its (resp_delay+1)-th cycle of seeing cyc&stb.
    int busy_n[3];
    initial begin
        slave_ack = 3'b000;
        s_dat_i   = '0;
        busy_n    = '{0, 0, 0};
        forever begin
            @(posedge wb_clk_i);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (s_cyc_o[k] && s_stb_o) begin
                    busy_n[k]++;
                    slave_ack[k] = (busy_n[k] - 1 == resp_delay);
                end else begin
                    busy_n[k]    = 0;
                    slave_ack[k] = 1'b0;
                end
                s_dat_i[32*k +: 32] = slave_ack[k] ? resp_data : $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge wb_clk_i);
        if (wb_rst_ni && wbs_ack_o) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: got ack with %h, expected no ack (cycle %0d)",
                         wbs_dat_o, cyc_cnt);
            end else begin
                check("ack_data", wbs_dat_o, exp_q.pop_front());
                check("ack_cycle", 32'(cyc_cnt), 32'(exp_cyc_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_txn(input logic [31:0] adr, input logic we, input int delay,
                          input logic [31:0] data, input bit clr_at_toerr);
        int  slv, issue, n;
        bit  to;
        slv = slave_of(adr);
        to  = (delay >= T);
        @(posedge wb_clk_i);
        #1;
        issue      = cyc_cnt;
        resp_delay = delay;
        resp_data  = data;
        wbs_adr_i  = adr;
        wbs_we_i   = we;
        wbs_dat_i  = $urandom;
        wbs_sel_i  = 4'hF;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        exp_q.push_back(to ? ERR : data);
        exp_cyc_q.push_back(issue + 1 + (to ? T : delay));
        if (to) begin
            exp_err = 1;
            exp_cnt = clr_at_toerr ? 1 : (exp_cnt < 255 ? exp_cnt + 1 : 255);
        end
        @(negedge wb_clk_i);
        check("decode_cyc_idle", {29'd0, s_cyc_o}, 32'd0);
        @(negedge wb_clk_i);
        check("route", {29'd0, s_cyc_o}, 32'(1 << slv));
        wbs_adr_i = $urandom;
        n = 0;
        while (!wbs_ack_o && n < T + 4) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (!wbs_ack_o) begin
            total++;
            $display("FAIL ack_wait: got no ack, expected ack within %0d cycles", T + 4);
            void'(exp_q.pop_back());
            void'(exp_cyc_q.pop_back());
        end else if (to) begin
            check("toerr_cyc", {29'd0, s_cyc_o}, 32'd0);
            if (clr_at_toerr) err_clr_i = 1'b1;
        end
        @(posedge wb_clk_i);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        err_clr_i = 1'b0;
        wbs_adr_i = 32'd0;
        @(negedge wb_clk_i);
        check("idle_dat", wbs_dat_o, 32'd0);
        check("err_o", {31'd0, err_o}, 32'(exp_err));
        check("err_cnt", {24'd0, err_cnt_o}, 32'(exp_cnt));
    endtask

    task automatic do_abort(input logic [31:0] adr);
        @(posedge wb_clk_i);
        #1;
        resp_delay = 1000;
        wbs_adr_i  = adr;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        repeat (2) begin
            @(posedge wb_clk_i);
            #1;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        check("abort_cyc", {29'd0, s_cyc_o}, 32'd0);
        repeat (T + 2) @(negedge wb_clk_i);
        check("abort_err", {31'd0, err_o}, 32'(exp_err));
        check("abort_cnt", {24'd0, err_cnt_o}, 32'(exp_cnt));
    endtask

    function automatic logic [31:0] rand_adr();
        case ($urandom_range(0, 3))
            0:       return 32'h300F_FFF8 + 32'($urandom_range(0, 7));
            1:       return 32'h300F_FFF0 + 32'($urandom_range(0, 7));
            2:       return $urandom;
            default: return ($urandom_range(0, 1) != 0) ? 32'h300F_FFEF : 32'h301F_FFF8;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        wb_rst_ni = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'd0;
        wbs_dat_i = 32'd0;
        err_clr_i = 1'b0;
        stray_ack = 3'b000;
        repeat (3) @(negedge wb_clk_i);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_cyc", {29'd0, s_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, s_stb_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_cnt", {24'd0, err_cnt_o}, 32'd0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;

        do_txn(32'h3000_0004, 1'b0, 3, 32'h1234_5678, 1'b0);
        do_txn(32'h300F_FFF8, 1'b1, 0, $urandom, 1'b0);
        do_txn(32'h300F_FFF4, 1'b1, 0, $urandom, 1'b0);
        do_txn(32'h3000_0000, 1'b0, 1000, $urandom, 1'b0);
        do_txn(32'h3000_0010, 1'b0, T - 1, 32'hA5A5_0001, 1'b0);

        @(posedge wb_clk_i);
        #1;
        stray_ack = 3'b110;
        do_txn(32'h3000_0020, 1'b0, 4, 32'h0BAD_F00D, 1'b0);
        stray_ack = 3'b000;

        do_abort(32'h3000_0030);
        do_txn(32'h300F_FFFC, 1'b0, 1, 32'h5555_AAAA, 1'b0);

        for (int i = 0; i < 40; i++)
            do_txn(rand_adr(), 1'($urandom_range(0, 1)), $urandom_range(0, T + 2), $urandom, 1'b0);

        @(posedge wb_clk_i);
        #1;
        err_clr_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        err_clr_i = 1'b0;
        exp_err = 0;
        exp_cnt = 0;
        @(negedge wb_clk_i);
        check("clr_err", {31'd0, err_o}, 32'd0);
        check("clr_cnt", {24'd0, err_cnt_o}, 32'd0);

        for (int i = 0; i < 300; i++)
            do_txn(rand_adr(), 1'b0, 1000, $urandom, 1'b0);
        check("sat_cnt", {24'd0, err_cnt_o}, 32'd255);
        do_txn(32'h3000_0040, 1'b0, 1000, $urandom, 1'b1);

        // Reset in the middle of a BUSY cycle.
        @(posedge wb_clk_i);
        #1;
        resp_delay = 1000;
        wbs_adr_i  = 32'h300F_FFF0;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("pre_rst_cyc", {29'd0, s_cyc_o}, 32'd2);
        #2;
        wb_rst_ni = 1'b0;
        exp_err   = 0;
        exp_cnt   = 0;
        #1;
        check("arst_cyc", {29'd0, s_cyc_o}, 32'd0);
        check("arst_stb", {31'd0, s_stb_o}, 32'd0);
        check("arst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("arst_err", {31'd0, err_o}, 32'd0);
        check("arst_cnt", {24'd0, err_cnt_o}, 32'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        do_txn(32'h300F_FFF9, 1'b0, 2, 32'hC0DE_0002, 1'b0);

        repeat (3) @(negedge wb_clk_i);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
